// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// Handshake: none; the controller is a free-running Moore FSM and the datapath samples strobes every clock.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with optional memory wait states in FETCH, MEM_READ and MEM_WRITE.
module mips_multicycle_control #(
  parameter int unsigned MEM_WAIT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.master   ctl
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       wait_last;

  logic       pc_write, pc_write_cond;
  logic       i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  assign wait_last = (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // wait_d defaults to 0 so every wait state is entered with a cleared counter.
  always_comb begin
    state_d = state_q;
    wait_d  = 4'd0;
    case (state_q)
      FETCH: begin
        if (wait_last) state_d = DECODE;
        else           wait_d  = wait_q + 4'd1;
      end
      DECODE: begin
        case (ctl.opcode)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDI_EX;
          default:       state_d = FETCH;
        endcase
      end
      MEM_ADDR: begin
        if      (ctl.opcode == OP_LW) state_d = MEM_READ;
        else if (ctl.opcode == OP_SW) state_d = MEM_WRITE;
        else                          state_d = FETCH;
      end
      MEM_READ: begin
        if (wait_last) state_d = MEM_WB;
        else           wait_d  = wait_q + 4'd1;
      end
      MEM_WRITE: begin
        if (wait_last) state_d = FETCH;
        else           wait_d  = wait_q + 4'd1;
      end
      EXECUTE:  state_d = R_WB;
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (wait_last) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (ctl.opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = wait_last;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural side effects are suppressed while reset is held, even before the edge lands.
  assign ctl.pc_en      = rst_n & (pc_write | (pc_write_cond & ctl.zero));
  assign ctl.ir_write   = rst_n & ir_write;
  assign ctl.mem_write  = rst_n & mem_write;
  assign ctl.reg_write  = rst_n & reg_write;
  assign ctl.instr_done = rst_n & instr_done;
  assign ctl.i_or_d     = i_or_d;
  assign ctl.mem_read   = mem_read;
  assign ctl.mem_to_reg = mem_to_reg;
  assign ctl.reg_dst    = reg_dst;
  assign ctl.alu_src_a  = alu_src_a;
  assign ctl.alu_src_b  = alu_src_b;
  assign ctl.alu_op     = alu_op;
  assign ctl.pc_source  = pc_source;
  assign ctl.illegal_op = illegal_op;
  assign ctl.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: one instance with no wait states, one with two,
// per-cycle expected output vectors queued by the driver and checked by a negedge monitor.
module tb_mips_multicycle_control;

  // Packed observation vector layout (MSB..LSB):
  // state[20:17] pc_en i_or_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write
  // alu_src_a alu_src_b[7:6] alu_op[5:4] pc_source[3:2] instr_done illegal_op
  localparam logic [20:0] PCEN   = 21'd1 << 16;
  localparam logic [20:0] IORD   = 21'd1 << 15;
  localparam logic [20:0] MEMRD  = 21'd1 << 14;
  localparam logic [20:0] MEMW   = 21'd1 << 13;
  localparam logic [20:0] IRW    = 21'd1 << 12;
  localparam logic [20:0] MTR    = 21'd1 << 11;
  localparam logic [20:0] RDST   = 21'd1 << 10;
  localparam logic [20:0] RW     = 21'd1 << 9;
  localparam logic [20:0] ASRC   = 21'd1 << 8;
  localparam logic [20:0] SRCB01 = 21'd1 << 6;
  localparam logic [20:0] SRCB10 = 21'd2 << 6;
  localparam logic [20:0] SRCB11 = 21'd3 << 6;
  localparam logic [20:0] OPSUB  = 21'd1 << 4;
  localparam logic [20:0] OPFN   = 21'd2 << 4;
  localparam logic [20:0] PS01   = 21'd1 << 2;
  localparam logic [20:0] PS10   = 21'd2 << 2;
  localparam logic [20:0] DONE   = 21'd1 << 1;
  localparam logic [20:0] ILL    = 21'd1;

  localparam logic [20:0] S0  = 21'd0  << 17;
  localparam logic [20:0] S1  = 21'd1  << 17;
  localparam logic [20:0] S2  = 21'd2  << 17;
  localparam logic [20:0] S3  = 21'd3  << 17;
  localparam logic [20:0] S4  = 21'd4  << 17;
  localparam logic [20:0] S5  = 21'd5  << 17;
  localparam logic [20:0] S6  = 21'd6  << 17;
  localparam logic [20:0] S7  = 21'd7  << 17;
  localparam logic [20:0] S8  = 21'd8  << 17;
  localparam logic [20:0] S9  = 21'd9  << 17;
  localparam logic [20:0] S10 = 21'd10 << 17;
  localparam logic [20:0] S11 = 21'd11 << 17;

  localparam logic [20:0] F_WAIT = S0 | MEMRD | SRCB01;
  localparam logic [20:0] F_LAST = S0 | MEMRD | SRCB01 | IRW | PCEN;
  localparam logic [20:0] DEC    = S1 | SRCB11;

  logic clk;
  logic rst_a, rst_b;

  mips_multicycle_control_if bus_a ();
  mips_multicycle_control_if bus_b ();

  mips_multicycle_control #(.MEM_WAIT_CYCLES(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .ctl   (bus_a)
  );

  mips_multicycle_control #(.MEM_WAIT_CYCLES(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .ctl   (bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [20:0] qa[$], qb[$];
  string       ta[$], tg[$];
  int          checks = 0;
  int          failures = 0;

  function automatic logic [20:0] obs_a();
    return {bus_a.state, bus_a.pc_en, bus_a.i_or_d, bus_a.mem_read, bus_a.mem_write,
            bus_a.ir_write, bus_a.mem_to_reg, bus_a.reg_dst, bus_a.reg_write,
            bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source,
            bus_a.instr_done, bus_a.illegal_op};
  endfunction

  function automatic logic [20:0] obs_b();
    return {bus_b.state, bus_b.pc_en, bus_b.i_or_d, bus_b.mem_read, bus_b.mem_write,
            bus_b.ir_write, bus_b.mem_to_reg, bus_b.reg_dst, bus_b.reg_write,
            bus_b.alu_src_a, bus_b.alu_src_b, bus_b.alu_op, bus_b.pc_source,
            bus_b.instr_done, bus_b.illegal_op};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [20:0] e, got;
    string       t;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      t = ta.pop_front();
      got = obs_a();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s (W=0): got %h expected %h", t, got, e);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      t = tg.pop_front();
      got = obs_b();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s (W=2): got %h expected %h", t, got, e);
      end
    end
  end

  // driver tasks
  task automatic step(input bit b, input logic [20:0] exp, input string tag);
    if (b) begin
      qb.push_back(exp);
      tg.push_back(tag);
    end else begin
      qa.push_back(exp);
      ta.push_back(tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit b, input logic [5:0] op, input logic z);
    if (b) begin
      bus_b.opcode = op;
      bus_b.zero   = z;
    end else begin
      bus_a.opcode = op;
      bus_a.zero   = z;
    end
  endtask

  task automatic fetch_b(input string tag);
    step(1, F_WAIT, {tag, "_fetch_w0"});
    step(1, F_WAIT, {tag, "_fetch_w1"});
    step(1, F_LAST, {tag, "_fetch_last"});
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    set_in(0, 6'b000000, 1'b0);
    set_in(1, 6'b000000, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // reset state: FETCH, but pc_en/ir_write suppressed while rst_n is low
    step(0, S0 | MEMRD | SRCB01, "reset_state");
    rst_a = 1'b1;

    // R-type
    set_in(0, 6'b000000, 1'b0);
    step(0, F_LAST, "r_fetch");
    step(0, DEC, "r_decode");
    step(0, S6 | ASRC | OPFN, "r_exec");
    step(0, S7 | RDST | RW | DONE, "r_wb");

    // lw, W=0
    set_in(0, 6'b100011, 1'b0);
    step(0, F_LAST, "lw0_fetch");
    step(0, DEC, "lw0_decode");
    step(0, S2 | ASRC | SRCB10, "lw0_addr");
    step(0, S3 | IORD | MEMRD, "lw0_read");
    step(0, S4 | MTR | RW | DONE, "lw0_wb");

    // beq taken, zero held high throughout
    set_in(0, 6'b000100, 1'b1);
    step(0, F_LAST, "beq1_fetch");
    step(0, DEC, "beq1_decode");
    step(0, S8 | ASRC | OPSUB | PS01 | DONE | PCEN, "beq1_branch");

    // beq not taken
    set_in(0, 6'b000100, 1'b0);
    step(0, F_LAST, "beq0_fetch");
    step(0, DEC, "beq0_decode");
    step(0, S8 | ASRC | OPSUB | PS01 | DONE, "beq0_branch");

    // j
    set_in(0, 6'b000010, 1'b1);
    step(0, F_LAST, "j_fetch");
    step(0, DEC, "j_decode");
    step(0, S9 | PCEN | PS10 | DONE, "j_jump");

    // addi
    set_in(0, 6'b001000, 1'b0);
    step(0, F_LAST, "addi_fetch");
    step(0, DEC, "addi_decode");
    step(0, S10 | ASRC | SRCB10, "addi_ex");
    step(0, S11 | RW | DONE, "addi_wb");

    // illegal opcode
    set_in(0, 6'b111111, 1'b1);
    step(0, F_LAST, "ill_fetch");
    step(0, DEC | ILL | DONE, "ill_decode");
    step(0, F_LAST, "ill_refetch");

    // reset asserted mid-instruction in EXECUTE
    set_in(0, 6'b000000, 1'b0);
    step(0, DEC, "rst_decode");
    rst_a = 1'b0;
    step(0, S6 | ASRC | OPFN, "rst_in_exec");
    step(0, S0 | MEMRD | SRCB01, "rst_fetch_held");
    rst_a = 1'b1;
    step(0, F_LAST, "rst_release");
    step(0, DEC, "rst_r_decode");
    step(0, S6 | ASRC | OPFN, "rst_r_exec");
    step(0, S7 | RDST | RW | DONE, "rst_r_wb");

    // lw then sw with two wait states
    rst_b = 1'b1;
    set_in(1, 6'b100011, 1'b0);
    fetch_b("lw2");
    step(1, DEC, "lw2_decode");
    step(1, S2 | ASRC | SRCB10, "lw2_addr");
    step(1, S3 | IORD | MEMRD, "lw2_read0");
    step(1, S3 | IORD | MEMRD, "lw2_read1");
    step(1, S3 | IORD | MEMRD, "lw2_read2");
    step(1, S4 | MTR | RW | DONE, "lw2_wb");

    set_in(1, 6'b101011, 1'b0);
    fetch_b("sw2");
    step(1, DEC, "sw2_decode");
    step(1, S2 | ASRC | SRCB10, "sw2_addr");
    step(1, S5 | IORD | MEMW, "sw2_write0");
    step(1, S5 | IORD | MEMW, "sw2_write1");
    step(1, S5 | IORD | MEMW | DONE, "sw2_write2");
    step(1, F_WAIT, "sw2_next_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: left %0d/%0d expected 0/0", qa.size(), qb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
